ps2_scan_decoder: RTL

Downstream consumer of the PS/2 receiver FIFO (`ps2_keyboard`). It pops raw scan-code bytes through the receiver's `ready`/`nextdata_n` handshake and folds `E0`/`F0` prefixes into single key events. It tracks the currently held key, suppresses typematic repeats from the press count, and presents registered event and key-state outputs. Those outputs feed `keycode_to_ascii` and the seven-segment display logic.

---
 rtl/ps2_scan_decoder_pkg.sv | 13 +
 rtl/ps2_scan_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// Shared PS/2 scan-code constants and the decoder FSM state encoding.
package ps2_scan_decoder_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

endpackage

// File: rtl/ps2_scan_decoder.sv
// Pops receiver FIFO bytes, folds E0/F0 prefixes into key events, tracks the held key.
// One byte per 3 cycles; event registered 3 edges after IDLE sees the last byte; pops only while ready=1.
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_seen
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             ev_valid_q, ev_valid_d;
  logic [7:0]       ev_code_q, ev_code_d;
  logic             ev_ext_q, ev_ext_d;
  logic             ev_break_q, ev_break_d;
  logic             ev_repeat_q, ev_repeat_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             ovf_seen_q, ovf_seen_d;
  logic             key_match;

  // Identity of a key is code plus extended flag; held-ness is checked separately.
  assign key_match = (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    ev_valid_d    = 1'b0;
    ev_code_d     = ev_code_q;
    ev_ext_d      = ev_ext_q;
    ev_break_d    = ev_break_q;
    ev_repeat_d   = ev_repeat_q;
    key_down_d    = key_down_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    press_count_d = press_count_q;
    ovf_seen_d    = ovf_seen_q | overflow;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == PS2_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == PS2_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          ev_valid_d  = 1'b1;
          ev_code_d   = byte_q;
          ev_ext_d    = ext_pend_q;
          ev_break_d  = brk_pend_q;
          ev_repeat_d = 1'b0;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
          if (!brk_pend_q) begin
            if (key_down_q && key_match) begin
              ev_repeat_d = 1'b1;
            end else begin
              key_down_d    = 1'b1;
              key_code_d    = byte_q;
              key_ext_d     = ext_pend_q;
              press_count_d = press_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else if (key_match) begin
            // Releasing the held key keeps its code for downstream display.
            key_down_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      ev_valid_q    <= 1'b0;
      ev_code_q     <= 8'h00;
      ev_ext_q      <= 1'b0;
      ev_break_q    <= 1'b0;
      ev_repeat_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      press_count_q <= '0;
      ovf_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      ev_valid_q    <= ev_valid_d;
      ev_code_q     <= ev_code_d;
      ev_ext_q      <= ev_ext_d;
      ev_break_q    <= ev_break_d;
      ev_repeat_q   <= ev_repeat_d;
      key_down_q    <= key_down_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      press_count_q <= press_count_d;
      ovf_seen_q    <= ovf_seen_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_ext      = ev_ext_q;
  assign ev_break    = ev_break_q;
  assign ev_repeat   = ev_repeat_q;
  assign key_down    = key_down_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign press_count = press_count_q;
  assign ovf_seen    = ovf_seen_q;

endmodule
